// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// MemReq/MemReady: MemReq is held high for the whole access; the access completes on the cycle MemReady is high.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic [1:0]       IDEX_Mem2RegSEL;
  logic [4:0]       IDEX_RegWBAddr;
  logic             EXMEM_Beq;
  logic             EXMEM_Bne;
  logic             EXMEM_ZeroFlag;
  logic [1:0]       EXMEM_Mem2RegSEL;
  logic             EXMEM_MemWriteEN;
  logic             MemReady;

  logic             PCWriteEN;
  logic             IFID_WriteEN;
  logic             PipeHold;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             EXMEM_Flush;
  logic             PCSrcSEL;
  logic             MemReq;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  logic             dbg_state;
  logic [7:0]       dbg_wait_cnt;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, IDEX_Mem2RegSEL, IDEX_RegWBAddr,
           EXMEM_Beq, EXMEM_Bne, EXMEM_ZeroFlag, EXMEM_Mem2RegSEL,
           EXMEM_MemWriteEN, MemReady,
    input  PCWriteEN, IFID_WriteEN, PipeHold, IFID_Flush, IDEX_Flush,
           EXMEM_Flush, PCSrcSEL, MemReq, MemTimeout, StallCount, FlushCount,
           dbg_state, dbg_wait_cnt
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, IDEX_Mem2RegSEL, IDEX_RegWBAddr,
           EXMEM_Beq, EXMEM_Bne, EXMEM_ZeroFlag, EXMEM_Mem2RegSEL,
           EXMEM_MemWriteEN, MemReady,
    output PCWriteEN, IFID_WriteEN, PipeHold, IFID_Flush, IDEX_Flush,
           EXMEM_Flush, PCSrcSEL, MemReq, MemTimeout, StallCount, FlushCount,
           dbg_state, dbg_wait_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: memory freeze, branch squash,
// load-use bubble, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int          CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic                   CLOCK,
  input logic                   RESET,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_op, taken, load_use, mem_release, freeze;
  logic stall_evt, flush_evt, timeout_evt;

  assign mem_op   = (hz.EXMEM_Mem2RegSEL == 2'b01) | hz.EXMEM_MemWriteEN;
  assign taken    = (hz.EXMEM_Beq & hz.EXMEM_ZeroFlag) | (hz.EXMEM_Bne & ~hz.EXMEM_ZeroFlag);
  assign load_use = (hz.IDEX_Mem2RegSEL == 2'b01) & (hz.IDEX_RegWBAddr != 5'd0) &
                    ((hz.IDEX_RegWBAddr == hz.ID_Rs) |
                     (hz.ID_UsesRt & (hz.IDEX_RegWBAddr == hz.ID_Rt)));

  // Release on completion or once the per-access freeze budget is used up.
  assign mem_release = hz.MemReady | (wait_cnt_q == 8'(MEM_TIMEOUT));
  assign freeze      = (state_q == RUN)     ? (mem_op & ~hz.MemReady) : ~mem_release;
  assign timeout_evt = (state_q == MEMWAIT) & mem_release & ~hz.MemReady;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (timeout_evt) timeout_q <= 1'b1;
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_op && !hz.MemReady) begin
          state_d    = MEMWAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEMWAIT: begin
        if (mem_release) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    hz.PCWriteEN    = 1'b1;
    hz.IFID_WriteEN = 1'b1;
    hz.PipeHold     = 1'b0;
    hz.IFID_Flush   = 1'b0;
    hz.IDEX_Flush   = 1'b0;
    hz.EXMEM_Flush  = 1'b0;
    hz.PCSrcSEL     = 1'b0;
    hz.MemReq       = mem_op | (state_q == MEMWAIT);
    stall_evt       = 1'b0;
    flush_evt       = 1'b0;
    if (RESET) begin
      hz.PCWriteEN    = 1'b0;
      hz.IFID_WriteEN = 1'b0;
      hz.IFID_Flush   = 1'b1;
      hz.IDEX_Flush   = 1'b1;
      hz.EXMEM_Flush  = 1'b1;
      hz.MemReq       = 1'b0;
    end else if (freeze) begin
      hz.PCWriteEN    = 1'b0;
      hz.IFID_WriteEN = 1'b0;
      hz.PipeHold     = 1'b1;
      hz.MemReq       = 1'b1;
      stall_evt       = 1'b1;
    end else if (taken) begin
      // A load-use hazard here is moot: the dependent instruction is squashed.
      hz.PCSrcSEL    = 1'b1;
      hz.IFID_Flush  = 1'b1;
      hz.IDEX_Flush  = 1'b1;
      hz.EXMEM_Flush = 1'b1;
      flush_evt      = 1'b1;
    end else if (load_use) begin
      hz.PCWriteEN    = 1'b0;
      hz.IFID_WriteEN = 1'b0;
      hz.IDEX_Flush   = 1'b1;
      stall_evt       = 1'b1;
    end
  end

  assign hz.MemTimeout   = timeout_q;
  assign hz.StallCount   = stall_cnt_q;
  assign hz.FlushCount   = flush_cnt_q;
  assign hz.dbg_state    = state_q;
  assign hz.dbg_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: default, short-timeout and narrow-counter instances share stimulus.
module tb_pipeline_hazard_ctrl;

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLOCK = ~CLOCK;

  logic [4:0] id_rs = '0, id_rt = '0, idex_wb = '0;
  logic       id_uses_rt = 1'b0;
  logic [1:0] idex_m2r = '0, exmem_m2r = '0;
  logic       beq = 1'b0, bne = 1'b0, zero = 1'b0, exmem_we = 1'b0, ready = 1'b0;
  logic [24:0] in_vec;

  assign in_vec = {id_rs, id_rt, id_uses_rt, idex_m2r, idex_wb,
                   beq, bne, zero, exmem_m2r, exmem_we, ready};

  pipeline_hazard_ctrl_if #(.CNT_W(16)) if_a ();
  pipeline_hazard_ctrl_if #(.CNT_W(16)) if_t ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  if_s ();

  assign {if_a.ID_Rs, if_a.ID_Rt, if_a.ID_UsesRt, if_a.IDEX_Mem2RegSEL, if_a.IDEX_RegWBAddr,
          if_a.EXMEM_Beq, if_a.EXMEM_Bne, if_a.EXMEM_ZeroFlag, if_a.EXMEM_Mem2RegSEL,
          if_a.EXMEM_MemWriteEN, if_a.MemReady} = in_vec;
  assign {if_t.ID_Rs, if_t.ID_Rt, if_t.ID_UsesRt, if_t.IDEX_Mem2RegSEL, if_t.IDEX_RegWBAddr,
          if_t.EXMEM_Beq, if_t.EXMEM_Bne, if_t.EXMEM_ZeroFlag, if_t.EXMEM_Mem2RegSEL,
          if_t.EXMEM_MemWriteEN, if_t.MemReady} = in_vec;
  assign {if_s.ID_Rs, if_s.ID_Rt, if_s.ID_UsesRt, if_s.IDEX_Mem2RegSEL, if_s.IDEX_RegWBAddr,
          if_s.EXMEM_Beq, if_s.EXMEM_Bne, if_s.EXMEM_ZeroFlag, if_s.EXMEM_Mem2RegSEL,
          if_s.EXMEM_MemWriteEN, if_s.MemReady} = in_vec;

  pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(255)) dut_a (.CLOCK(CLOCK), .RESET(RESET), .hz(if_a.slave));
  pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4))   dut_t (.CLOCK(CLOCK), .RESET(RESET), .hz(if_t.slave));
  pipeline_hazard_ctrl #(.CNT_W(2),  .MEM_TIMEOUT(255)) dut_s (.CLOCK(CLOCK), .RESET(RESET), .hz(if_s.slave));

  // {PCWriteEN, IFID_WriteEN, PipeHold, IFID_Flush, IDEX_Flush, EXMEM_Flush, PCSrcSEL, MemReq}
  logic [7:0] ctl_a, ctl_t, ctl_s;
  assign ctl_a = {if_a.PCWriteEN, if_a.IFID_WriteEN, if_a.PipeHold, if_a.IFID_Flush,
                  if_a.IDEX_Flush, if_a.EXMEM_Flush, if_a.PCSrcSEL, if_a.MemReq};
  assign ctl_t = {if_t.PCWriteEN, if_t.IFID_WriteEN, if_t.PipeHold, if_t.IFID_Flush,
                  if_t.IDEX_Flush, if_t.EXMEM_Flush, if_t.PCSrcSEL, if_t.MemReq};
  assign ctl_s = {if_s.PCWriteEN, if_s.IFID_WriteEN, if_s.PipeHold, if_s.IFID_Flush,
                  if_s.IDEX_Flush, if_s.EXMEM_Flush, if_s.PCSrcSEL, if_s.MemReq};

  localparam logic [7:0] CTL_RESET  = 8'b0001_1100;
  localparam logic [7:0] CTL_NORMAL = 8'b1100_0000;
  localparam logic [7:0] CTL_MEMOK  = 8'b1100_0001;
  localparam logic [7:0] CTL_LDUSE  = 8'b0000_1000;
  localparam logic [7:0] CTL_BRANCH = 8'b1101_1110;
  localparam logic [7:0] CTL_FREEZE = 8'b0010_0001;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; idex_m2r = '0; idex_wb = '0;
    beq = 1'b0; bne = 1'b0; zero = 1'b0; exmem_m2r = '0; exmem_we = 1'b0; ready = 1'b0;
  endtask

  initial begin
    // Reset, with a memory op present to show MemReq stays low
    exmem_we = 1'b1;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK); #1;
    chk("reset_ctl_a", ctl_a, CTL_RESET);
    chk("reset_ctl_t", ctl_t, CTL_RESET);
    @(negedge CLOCK);
    RESET = 1'b0; exmem_we = 1'b0; #1;
    chk("idle_ctl", ctl_a, CTL_NORMAL);
    chk("reset_stall", if_a.StallCount, 0);
    chk("reset_flush", if_a.FlushCount, 0);
    chk("reset_timeout", if_a.MemTimeout, 0);
    chk("reset_state", if_a.dbg_state, 0);
    chk("reset_wait", if_a.dbg_wait_cnt, 0);

    // Load-use on Rs
    @(negedge CLOCK);
    idex_m2r = 2'b01; idex_wb = 5'd8; id_rs = 5'd8; #1;
    chk("lduse_rs_ctl", ctl_a, CTL_LDUSE);
    @(negedge CLOCK);
    idex_m2r = 2'b00; #1;
    chk("lduse_rs_cnt", if_a.StallCount, 1);
    chk("lduse_clear_ctl", ctl_a, CTL_NORMAL);

    // Load-use on Rt, then Rt match ignored when unused, then r0 destination
    @(negedge CLOCK);
    idex_m2r = 2'b01; idex_wb = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1; #1;
    chk("lduse_rt_ctl", ctl_a, CTL_LDUSE);
    @(negedge CLOCK);
    id_uses_rt = 1'b0; #1;
    chk("rt_unused_ctl", ctl_a, CTL_NORMAL);
    chk("lduse_rt_cnt", if_a.StallCount, 2);
    @(negedge CLOCK);
    idex_wb = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1; #1;
    chk("r0_no_stall_ctl", ctl_a, CTL_NORMAL);

    // Branches
    @(negedge CLOCK);
    clear_inputs(); beq = 1'b1; zero = 1'b1; #1;
    chk("r0_stall_cnt", if_a.StallCount, 2);
    chk("beq_taken_ctl", ctl_a, CTL_BRANCH);
    @(negedge CLOCK);
    zero = 1'b0; #1;
    chk("beq_not_taken_ctl", ctl_a, CTL_NORMAL);
    chk("beq_flush_cnt", if_a.FlushCount, 1);
    @(negedge CLOCK);
    beq = 1'b0; bne = 1'b1; zero = 1'b0; #1;
    chk("bne_taken_ctl", ctl_a, CTL_BRANCH);
    @(negedge CLOCK);
    zero = 1'b1; #1;
    chk("bne_not_taken_ctl", ctl_a, CTL_NORMAL);
    chk("bne_flush_cnt", if_a.FlushCount, 2);

    // Load-use coinciding with a taken branch: squash wins
    @(negedge CLOCK);
    bne = 1'b1; zero = 1'b0; idex_m2r = 2'b01; idex_wb = 5'd8; id_rs = 5'd8; #1;
    chk("lduse_taken_ctl", ctl_a, CTL_BRANCH);
    @(negedge CLOCK);
    clear_inputs(); #1;
    chk("lduse_taken_stall", if_a.StallCount, 2);
    chk("lduse_taken_flush", if_a.FlushCount, 3);

    // Load waiting 3 cycles for MemReady
    @(negedge CLOCK);
    exmem_m2r = 2'b01; ready = 1'b0; #1;
    chk("freeze1_ctl", ctl_a, CTL_FREEZE);
    chk("freeze1_ctl_t", ctl_t, CTL_FREEZE);
    chk("freeze1_state", if_a.dbg_state, 0);
    for (int i = 2; i <= 3; i++) begin
      @(negedge CLOCK); #1;
      chk("freeze_n_ctl", ctl_a, CTL_FREEZE);
      chk("freeze_n_state", if_a.dbg_state, 1);
      chk("freeze_n_wait", if_a.dbg_wait_cnt, i - 1);
    end
    @(negedge CLOCK);
    ready = 1'b1; #1;
    chk("mem_release_ctl", ctl_a, CTL_MEMOK);
    chk("mem_release_ctl_t", ctl_t, CTL_MEMOK);
    @(negedge CLOCK);
    clear_inputs(); #1;
    chk("mem_done_state", if_a.dbg_state, 0);
    chk("mem_done_stall", if_a.StallCount, 5);
    chk("mem_done_timeout", if_a.MemTimeout, 0);
    chk("mem_done_ctl", ctl_a, CTL_NORMAL);

    // Store that never completes: short-timeout instance releases after 4 frozen cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK);
      exmem_we = 1'b1; #1;
      chk("to_freeze_ctl_t", ctl_t, CTL_FREEZE);
      chk("to_freeze_wait_t", if_t.dbg_wait_cnt, i);
    end
    @(negedge CLOCK); #1;
    chk("to_release_ctl_t", ctl_t, CTL_MEMOK);
    chk("to_release_wait_t", if_t.dbg_wait_cnt, 4);
    chk("to_release_flag_pre", if_t.MemTimeout, 0);
    @(negedge CLOCK);
    exmem_we = 1'b0; #1;
    chk("to_flag_set", if_t.MemTimeout, 1);
    chk("to_state_t", if_t.dbg_state, 0);
    chk("to_stall_t", if_t.StallCount, 9);
    chk("long_wait_ctl_a", ctl_a, CTL_FREEZE);
    chk("long_wait_state_a", if_a.dbg_state, 1);
    @(negedge CLOCK); #1;
    chk("to_flag_sticky", if_t.MemTimeout, 1);
    chk("to_after_ctl_t", ctl_t, CTL_NORMAL);
    chk("long_wait_stall_a", if_a.StallCount, 11);

    // Reset while the default instance is still in MEMWAIT
    @(negedge CLOCK);
    RESET = 1'b1; exmem_we = 1'b1; #1;
    chk("reset_midwait_ctl", ctl_a, CTL_RESET);
    @(negedge CLOCK);
    RESET = 1'b0; exmem_we = 1'b0; #1;
    chk("post_reset_state", if_a.dbg_state, 0);
    chk("post_reset_stall", if_a.StallCount, 0);
    chk("post_reset_flush", if_a.FlushCount, 0);
    chk("post_reset_ctl", ctl_a, CTL_NORMAL);
    chk("post_reset_timeout_t", if_t.MemTimeout, 0);

    // Five taken branches into the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK);
      beq = 1'b1; zero = 1'b1; #1;
      chk("sat_ctl_s", ctl_s, CTL_BRANCH);
      chk("sat_flush_s", if_s.FlushCount, (i > 3) ? 3 : i);
    end
    @(negedge CLOCK);
    clear_inputs(); #1;
    chk("sat_flush_final_s", if_s.FlushCount, 3);
    chk("sat_flush_final_a", if_a.FlushCount, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush scheduler for the 5-stage pipeline. It watches the decode stage, the ID/EX and EX/MEM pipeline registers, and the data-memory handshake. It drives the PC and stage-register enables, flushes, and the branch-select line. It owns three decisions: branch-taken squash when a branch resolves in MEM, load-use bubble insertion in ID, and whole-pipeline freeze while a data-memory access waits for `MemReady`. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `CNT_W`, 16: width of `StallCount` and `FlushCount`.
- `MEM_TIMEOUT`, 255: maximum freeze cycles per memory access before forced release. Legal range 1..255.
- `CLOCK` in 1: single clock; all state changes on the rising edge.
- `RESET` in 1: synchronous reset, active-high.
- `ID_Rs`, `ID_Rt` in 5: source register numbers of the instruction in ID.
- `ID_UsesRt` in 1: the instruction in ID reads `Rt` as a source.
- `IDEX_Mem2RegSEL` in 2: ID/EX write-back select; `2'b01` means the instruction is a load.
- `IDEX_RegWBAddr` in 5: ID/EX destination register.
- `EXMEM_Beq`, `EXMEM_Bne`, `EXMEM_ZeroFlag` in 1 each: branch type and ALU zero flag in MEM.
- `EXMEM_Mem2RegSEL` in 2, `EXMEM_MemWriteEN` in 1: memory operation in MEM; a load is `2'b01`.
- `MemReady` in 1: data memory completes the current access this cycle.
- `PCWriteEN` out 1: PC register update enable.
- `IFID_WriteEN` out 1: IF/ID register update enable.
- `PipeHold` out 1: hold ID/EX, EX/MEM and MEM/WB contents.
- `IFID_Flush`, `IDEX_Flush`, `EXMEM_Flush` out 1 each: load a bubble (all control enables 0) into that register.
- `PCSrcSEL` out 1: 1 selects `PCBranch` as the next PC.
- `MemReq` out 1: data-memory request.
- `MemTimeout` out 1: sticky flag; an access was force-released.
- `StallCount` out `CNT_W`: saturating count of stall/freeze cycles.
- `FlushCount` out `CNT_W`: saturating count of taken branches.

## Operation
- Signal definitions:
  - `MemOp` = (`EXMEM_Mem2RegSEL` == `2'b01`) | `EXMEM_MemWriteEN`.
  - `Taken` = (`EXMEM_Beq` & `EXMEM_ZeroFlag`) | (`EXMEM_Bne` & ~`EXMEM_ZeroFlag`).
  - `LoadUse` = (`IDEX_Mem2RegSEL` == `2'b01`) & (`IDEX_RegWBAddr` != 0) & ((`IDEX_RegWBAddr` == `ID_Rs`) | (`ID_UsesRt` & `IDEX_RegWBAddr` == `ID_Rt`)).
- State machine: states RUN and MEMWAIT, plus an 8-bit `WaitCnt`.
- RUN, `MemOp` & ~`MemReady` (freeze):
  - `PipeHold`=1, `PCWriteEN`=0, `IFID_WriteEN`=0, all flushes 0, `MemReq`=1.
  - Next state MEMWAIT, `WaitCnt`←1.
- MEMWAIT:
  - `MemReq`=1.
  - If `MemReady` or `WaitCnt`==`MEM_TIMEOUT`: release this cycle (normal RUN outputs), next state RUN, `WaitCnt`←0. Set `MemTimeout` if `MemReady`=0.
  - Otherwise: freeze outputs as above, `WaitCnt`++.
- RUN with `MemOp` & `MemReady`: `MemReq`=1, no stall.
- RUN, not frozen, `Taken`:
  - `PCSrcSEL`=1.
  - `IFID_Flush`=`IDEX_Flush`=`EXMEM_Flush`=1.
  - `PCWriteEN`=1, `IFID_WriteEN`=1.
  - `FlushCount`++.
- RUN, not frozen, not `Taken`, `LoadUse`:
  - `PCWriteEN`=0, `IFID_WriteEN`=0, `IDEX_Flush`=1.
  - `StallCount`++.
- Otherwise all enables 1, flushes 0, `PCSrcSEL`=0.
- Priority: freeze > branch flush > load-use. A load-use hazard coinciding with `Taken` is squashed, not stalled.
- `StallCount` increments on every freeze cycle and every load-use cycle.
- Both counters saturate at all-ones.

## Timing
- Outputs are combinational from the registered state and the current inputs; the decision takes effect at the next edge.
- Zero-latency branch redirect: `PCSrcSEL` is asserted in the same cycle `Taken` is seen in MEM.
- A load-use stall lasts exactly 1 cycle; the condition clears itself once the load advances to MEM.
- Maximum freeze per access is `MEM_TIMEOUT` cycles; the release cycle itself is not frozen.
- While `RESET`=1:
  - `PCWriteEN`=0, `IFID_WriteEN`=0, `PipeHold`=0.
  - All flushes 1.
  - `PCSrcSEL`=0, `MemReq`=0.
- After the reset edge: state RUN, `WaitCnt`=0, `MemTimeout`=0, `StallCount`=0, `FlushCount`=0.
- Reset asserted mid-MEMWAIT aborts the wait; it has priority over everything.

## Test plan
- Load `r8` in ID/EX (`IDEX_Mem2RegSEL`=01, `IDEX_RegWBAddr`=8), `ID_Rs`=8 -> 1 cycle with `PCWriteEN`=0, `IFID_WriteEN`=0, `IDEX_Flush`=1, `StallCount` 0→1. Repeat with `IDEX_RegWBAddr`=0 -> no stall.
- `EXMEM_Beq`=1, `ZeroFlag`=1 -> `PCSrcSEL`=1 and all three flushes 1 that cycle, `FlushCount`=1. Same with `ZeroFlag`=0 -> no flush. `EXMEM_Bne`=1, `ZeroFlag`=0 -> flush.
- `MemOp` with `MemReady` low for 3 cycles, high on the 4th -> `PipeHold`=1 for exactly 3 cycles, released on the 4th, `StallCount`=3, `MemTimeout`=0.
- `MEM_TIMEOUT`=4, `MemReady` never high -> 4 freeze cycles, release on the 5th, `MemTimeout`=1 and stays 1.
- `LoadUse` and `Taken` in the same cycle -> flush only, `StallCount` unchanged. `RESET` asserted during MEMWAIT -> next cycle RUN, counters 0, `MemReq`=0.
- `CNT_W`=2, 5 taken branches -> `FlushCount` saturates at 3.
